operand_byte_sender: RTL

Drives the byte-wide operand load interface of the peripherals unit from the host side. It accepts two 32-bit operands on a start command and serializes them into eight bytes, A then B, each least-significant byte first. Each byte is announced with a single-cycle enter strobe. After the eighth strobe it waits for the consumer's ready flag, then reports completion or timeout. It sits between a test or automation controller and the existing switch/enter operand path.

---
 rtl/operand_byte_sender.sv | 90 +++++++++
 1 files changed

// File: rtl/operand_byte_sender.sv
// operand_byte_sender: sends {opB,opA} as eight LSB-first bytes with enter strobes, then waits for ready_in; ports clk, reset, start, opA, opB, ready_in -> busy, byte_out, byte_idx, enter_pulse, done, timeout
module operand_byte_sender #(
  parameter int GAP = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        ready_in,
  output logic        busy,
  output logic [7:0]  byte_out,
  output logic [2:0]  byte_idx,
  output logic        enter_pulse,
  output logic        done,
  output logic        timeout
);
  typedef enum logic [2:0] {IDLE, HOLD, STROBE, WAIT_READY, FINISH} state_t;
  state_t state, state_n;
  logic [63:0] shreg, shreg_n;
  logic [2:0] idx, idx_n;
  logic [7:0] gcnt, gcnt_n;
  logic [15:0] tcnt, tcnt_n;
  logic done_n, timeout_n;
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    idx_n = idx;
    gcnt_n = gcnt;
    tcnt_n = tcnt;
    done_n = 1'b0;
    timeout_n = timeout;
    case (state)
      IDLE: if (start) begin
        state_n = HOLD;
        shreg_n = {opB, opA};
        idx_n = 3'd0;
        gcnt_n = 8'(GAP - 1);
        timeout_n = 1'b0;
      end
      HOLD: if (gcnt == 8'd0) state_n = STROBE; else gcnt_n = gcnt - 8'd1;
      STROBE: if (idx == 3'd7) begin
        state_n = WAIT_READY;
        tcnt_n = 16'(TIMEOUT - 1);
      end else begin
        state_n = HOLD;
        shreg_n = shreg >> 8;
        idx_n = idx + 3'd1;
        gcnt_n = 8'(GAP - 1);
      end
      WAIT_READY: if (ready_in) begin
        state_n = FINISH;
        done_n = 1'b1;
      end else if (tcnt == 16'd0) begin
        state_n = FINISH;
        timeout_n = 1'b1;
      end else tcnt_n = tcnt - 16'd1;
      FINISH: begin
        state_n = IDLE;
        shreg_n = '0;
        idx_n = 3'd0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      idx <= 3'd0;
      gcnt <= 8'd0;
      tcnt <= 16'd0;
      done <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      idx <= idx_n;
      gcnt <= gcnt_n;
      tcnt <= tcnt_n;
      done <= done_n;
      timeout <= timeout_n;
    end
  end
  assign busy = state != IDLE;
  assign enter_pulse = state == STROBE;
  assign byte_out = shreg[7:0];
  assign byte_idx = idx;
endmodule
